pkt_arbiter: RTL and testbench
==============================

PKT_ARBITER -- requirements
Module: pkt_arbiter

Interface
REQ-001 SHALL have parameter NUM_SRC, default 2, number of upstream Avalon-ST packet sources (legal 2..4).
REQ-002 SHALL have parameter DATA_W, default 64, data bus width in bits (8 bytes per beat, byte 0 in bits [63:56]).
REQ-003 SHALL have parameter EMPTY_W, default 3, width of the empty field.
REQ-004 Port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-005 Port reset_n, input, 1, asynchronous active-low reset.
REQ-006 Port src_valid, input, NUM_SRC, per-source beat valid.
REQ-007 Port src_ready, output, NUM_SRC, per-source beat accept.
REQ-008 Port src_sop / src_eop, input, NUM_SRC each, per-source start and end of packet.
REQ-009 Port src_empty, input, NUM_SRC*EMPTY_W, per-source count of unused bytes on the eop beat.
REQ-010 Port src_data, input, NUM_SRC*DATA_W, per-source beat data; source i occupies slice i.
REQ-011 Port out_valid / out_sop / out_eop, output, 1 each, stream to pkt_parser data_packet.
REQ-012 Port out_empty, output, EMPTY_W; out_data, output, DATA_W.
REQ-013 Port out_ready, input, 1, downstream accept from pkt_parser.
REQ-014 Port grant, output, NUM_SRC, one-hot owner of the output stream; 0 when idle.
REQ-015 Port proto_err, output, 1, single-cycle pulse on a source protocol violation.
REQ-016 Port pkt_cnt, output, NUM_SRC*16, per-source count of forwarded packets.

Function
REQ-017 SHALL implement an FSM with states IDLE and LOCKED.
REQ-018 In IDLE, a source is requesting when src_valid[i] and src_sop[i] are both 1.
REQ-019 In IDLE, round-robin SHALL pick the first requesting source scanning from rr_ptr+1 upward, modulo NUM_SRC.
REQ-020 On a pick, the FSM SHALL register grant one-hot and move to LOCKED at the next edge; no src_ready is asserted in the IDLE cycle.
REQ-021 In LOCKED, src_ready[g] SHALL equal pipe_ready; every other src_ready SHALL be 0 except as stated in REQ-024.
REQ-022 pipe_ready SHALL equal (!out_valid || out_ready).
REQ-023 Output SHALL be a single register stage: an accepted beat (src_valid[g] && src_ready[g]) loads out_* with data, sop, eop and empty unmodified, and sets out_valid. Latency is 1 cycle from accept. When there is no accept and out_ready is 1, out_valid clears. When out_ready is 0, out_* hold.
REQ-024 In any state, a non-granted source presenting valid without sop SHALL get src_ready[i]=1; the beat is discarded and proto_err pulses.
REQ-025 In LOCKED, an accepted beat with sop=1 that is not the first beat of the packet SHALL be forwarded unchanged, with a proto_err pulse.
REQ-026 Accepting a beat with eop=1 from the granted source SHALL, at that edge, set rr_ptr to g, clear grant, return to IDLE and increment pkt_cnt[g].
REQ-027 A single-beat packet (sop=eop=1) SHALL be handled per REQ-026.
REQ-028 pkt_cnt entries SHALL wrap from 0xFFFF to 0x0000.
REQ-029 Throughput SHALL be one beat per cycle within a packet, with exactly one idle cycle between packets.
REQ-030 Grant SHALL never change mid-packet, whatever the upstream valid gaps or downstream backpressure.

Reset
REQ-031 When reset_n is 0: state=IDLE, rr_ptr=NUM_SRC-1 (so source 0 wins first), grant=0, out_valid=out_sop=out_eop=0, out_empty=0, out_data=0, src_ready=0, proto_err=0, all pkt_cnt=0.
REQ-032 Reset asserted mid-packet SHALL abort the packet immediately; no partial beat is emitted after reset_n is released.

Verification
REQ-033 Single source: src0 sends a 3-beat packet with eop empty=5 and out_ready=1 -> out beats match 1 cycle after accept, out_empty=5, grant=01 during the packet, pkt_cnt[0]=1.
REQ-034 Contention: both sources hold sop after reset -> src0 packet is forwarded entire, then one idle cycle, then src1 packet; a third round goes to src0.
REQ-035 Backpressure: out_ready toggles 1,0,0,1 mid-packet -> no beat lost or duplicated, out_* stable while out_ready=0, grant unchanged.
REQ-036 Error: src1 presents valid with sop=0 while src0 is locked -> src1 beat consumed, proto_err high 1 cycle, src0 stream unaffected.
REQ-037 Reset mid-packet: reset_n pulsed low during beat 2 -> all outputs at reset values, next packet forwarded cleanly from src0.
REQ-038 Soak: 1000 random packets of 200..1500 bytes from each source into pkt_parser -> parser message scoreboard passes, and pkt_cnt totals equal the packets sent.

Source files
------------

// File: rtl/pkt_arbiter.sv
// pkt_arbiter: round-robin, packet-locked arbiter merging NUM_SRC Avalon-ST
// sources onto one output stream through a single output register stage.
module pkt_arbiter #(
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned EMPTY_W = 3
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_SRC-1:0]         src_valid,
  output logic [NUM_SRC-1:0]         src_ready,
  input  logic [NUM_SRC-1:0]         src_sop,
  input  logic [NUM_SRC-1:0]         src_eop,
  input  logic [NUM_SRC*EMPTY_W-1:0] src_empty,
  input  logic [NUM_SRC*DATA_W-1:0]  src_data,
  output logic                       out_valid,
  output logic                       out_sop,
  output logic                       out_eop,
  output logic [EMPTY_W-1:0]         out_empty,
  output logic [DATA_W-1:0]          out_data,
  input  logic                       out_ready,
  output logic [NUM_SRC-1:0]         grant,
  output logic                       proto_err,
  output logic [NUM_SRC*16-1:0]      pkt_cnt
);

  localparam int unsigned IDX_W = (NUM_SRC > 2) ? 2 : 1;

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_e;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]      gidx_q, gidx_d;
  logic [NUM_SRC-1:0]    grant_q, grant_d;
  logic                  first_q, first_d;
  logic                  proto_err_q, proto_err_d;
  logic                  out_valid_q, out_sop_q, out_eop_q;
  logic [EMPTY_W-1:0]    out_empty_q;
  logic [DATA_W-1:0]     out_data_q;
  logic [NUM_SRC*16-1:0] pkt_cnt_q;

  logic [NUM_SRC-1:0]    ready_c;
  logic                  pipe_ready, accept, found;
  logic                  g_valid, g_sop, g_eop;
  logic [EMPTY_W-1:0]    g_empty;
  logic [DATA_W-1:0]     g_data;
  int unsigned           cand;

  // Select the beat presented by the currently granted source.
  always_comb begin
    g_valid = 1'b0;
    g_sop   = 1'b0;
    g_eop   = 1'b0;
    g_empty = '0;
    g_data  = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (gidx_q == IDX_W'(i)) begin
        g_valid = src_valid[i];
        g_sop   = src_sop[i];
        g_eop   = src_eop[i];
        g_empty = src_empty[i*EMPTY_W +: EMPTY_W];
        g_data  = src_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Arbitration FSM next state, per-source ready and protocol-error detection.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gidx_d      = gidx_q;
    grant_d     = grant_q;
    first_d     = first_q;
    ready_c     = '0;
    proto_err_d = 1'b0;
    accept      = 1'b0;
    found       = 1'b0;
    cand        = '0;
    pipe_ready  = !out_valid_q || out_ready;

    // Stray mid-packet beats from non-owners are swallowed so they cannot stall.
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (!grant_q[i] && src_valid[i] && !src_sop[i]) begin
        ready_c[i]  = 1'b1;
        proto_err_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        for (int unsigned k = 1; k <= NUM_SRC; k++) begin
          cand = (32'(rr_ptr_q) + k) % NUM_SRC;
          for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (!found && cand == i && src_valid[i] && src_sop[i]) begin
              found      = 1'b1;
              gidx_d     = IDX_W'(i);
              grant_d    = '0;
              grant_d[i] = 1'b1;
              first_d    = 1'b1;
              state_d    = LOCKED;
            end
          end
        end
      end
      LOCKED: begin
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
          if (gidx_q == IDX_W'(i)) ready_c[i] = pipe_ready;
        end
        accept = g_valid && pipe_ready;
        if (accept) begin
          first_d = 1'b0;
          if (g_sop && !first_q) proto_err_d = 1'b1;
          if (g_eop) begin
            state_d  = IDLE;
            grant_d  = '0;
            rr_ptr_d = gidx_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Ready is forced low while reset is held so nothing is consumed.
  assign src_ready = ready_c & {NUM_SRC{reset_n}};
  assign out_valid = out_valid_q;
  assign out_sop   = out_sop_q;
  assign out_eop   = out_eop_q;
  assign out_empty = out_empty_q;
  assign out_data  = out_data_q;
  assign grant     = grant_q;
  assign proto_err = proto_err_q;
  assign pkt_cnt   = pkt_cnt_q;

  // State, output register stage and per-source packet counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= IDX_W'(NUM_SRC - 1);
      gidx_q      <= '0;
      grant_q     <= '0;
      first_q     <= 1'b0;
      proto_err_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_empty_q <= '0;
      out_data_q  <= '0;
      pkt_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      gidx_q      <= gidx_d;
      grant_q     <= grant_d;
      first_q     <= first_d;
      proto_err_q <= proto_err_d;
      if (accept) begin
        out_valid_q <= 1'b1;
        out_sop_q   <= g_sop;
        out_eop_q   <= g_eop;
        out_empty_q <= g_empty;
        out_data_q  <= g_data;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (accept && g_eop) begin
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
          if (gidx_q == IDX_W'(i)) pkt_cnt_q[i*16 +: 16] <= pkt_cnt_q[i*16 +: 16] + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pkt_arbiter.sv
// Self-checking bench for pkt_arbiter: directed scenarios plus a random soak,
// checked against a packet-level scoreboard and handshake rules.
module tb_pkt_arbiter;

  localparam int NS = 2;

  typedef struct packed {
    logic [63:0] data;
    logic        sop;
    logic        eop;
    logic [2:0]  empty;
  } beat_t;

  typedef struct {
    int cyc;
    int src;
  } acc_t;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [NS-1:0]     src_valid, src_ready, src_sop, src_eop;
  logic [NS*3-1:0]   src_empty;
  logic [NS*64-1:0]  src_data;
  logic              out_valid, out_sop, out_eop, out_ready;
  logic [2:0]        out_empty;
  logic [63:0]       out_data;
  logic [NS-1:0]     grant;
  logic              proto_err;
  logic [NS*16-1:0]  pkt_cnt;

  logic        sv[NS], ss[NS], se[NS], rdy[NS], drv_on[NS], last_disc[NS];
  logic [2:0]  sm[NS];
  logic [63:0] sd[NS];
  logic [15:0] cnt_o[NS];

  assign src_valid = {sv[1], sv[0]};
  assign src_sop   = {ss[1], ss[0]};
  assign src_eop   = {se[1], se[0]};
  assign src_empty = {sm[1], sm[0]};
  assign src_data  = {sd[1], sd[0]};
  assign rdy[0]    = src_ready[0];
  assign rdy[1]    = src_ready[1];
  assign cnt_o[0]  = pkt_cnt[15:0];
  assign cnt_o[1]  = pkt_cnt[31:16];

  always #5 clk = ~clk;

  pkt_arbiter #(.NUM_SRC(NS), .DATA_W(64), .EMPTY_W(3)) dut (
    .clk(clk), .reset_n(reset_n),
    .src_valid(src_valid), .src_ready(src_ready), .src_sop(src_sop), .src_eop(src_eop),
    .src_empty(src_empty), .src_data(src_data),
    .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop), .out_empty(out_empty),
    .out_data(out_data), .out_ready(out_ready),
    .grant(grant), .proto_err(proto_err), .pkt_cnt(pkt_cnt)
  );

  int    vectors = 0, miscompares = 0;
  int    cyc = 0, owner = -1, cur_src = -1, perr_cnt = 0;
  int    valid_pct = 100, ordy_pct = 100;
  int    cnt_model[NS], sent[NS], rcv_cnt[NS];
  beat_t drv_q[NS][$];
  beat_t exp_q[NS][$];
  logic  ordy_pat[$];
  acc_t  acc_log[$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic busy();
    logic b = 1'b0;
    for (int i = 0; i < NS; i++) if (drv_q[i].size() > 0 || exp_q[i].size() > 0) b = 1'b1;
    return b;
  endfunction

  task automatic add_pkt(input int s, input int nb, input logic [2:0] emp, input int mid_sop);
    beat_t b;
    for (int k = 0; k < nb; k++) begin
      b.data  = {$urandom, $urandom};
      b.sop   = (k == 0) || (k == mid_sop);
      b.eop   = (k == nb - 1);
      b.empty = (k == nb - 1) ? emp : 3'd0;
      drv_q[s].push_back(b);
      exp_q[s].push_back(b);
    end
    sent[s]++;
  endtask

  task automatic drive();
    for (int i = 0; i < NS; i++) begin
      drv_on[i] = 1'b0; sv[i] = 1'b0; ss[i] = 1'b0; se[i] = 1'b0; sm[i] = '0; sd[i] = '0;
      if (drv_q[i].size() > 0 && $urandom_range(99) < 32'(valid_pct)) begin
        drv_on[i] = 1'b1;
        sv[i] = 1'b1;
        ss[i] = drv_q[i][0].sop;
        se[i] = drv_q[i][0].eop;
        sm[i] = drv_q[i][0].empty;
        sd[i] = drv_q[i][0].data;
      end
    end
    if (ordy_pat.size() > 0) out_ready = ordy_pat.pop_front();
    else out_ready = ($urandom_range(99) < 32'(ordy_pct));
  endtask

  task automatic score(input beat_t b);
    beat_t e;
    logic  found;
    if (cur_src < 0) begin
      chk("sb_sop", b.sop, 1'b1);
      found = 1'b0;
      for (int i = 0; i < NS; i++)
        if (!found && exp_q[i].size() > 0 && exp_q[i][0].data == b.data) begin
          found = 1'b1;
          cur_src = i;
        end
      chk("sb_known_pkt", found, 1'b1);
      if (!found) return;
    end
    chk("sb_beat_expected", exp_q[cur_src].size() > 0, 1'b1);
    if (exp_q[cur_src].size() == 0) return;
    e = exp_q[cur_src].pop_front();
    chk("sb_beat", b, e);
    if (b.eop) begin
      rcv_cnt[cur_src]++;
      cur_src = -1;
    end
  endtask

  // One clock cycle: inputs already driven; sample handshakes before the edge,
  // then check the output register and handshake rules after it.
  task automatic step();
    logic          a[NS];
    beat_t         hb[NS];
    beat_t         po;
    logic          pov, obv, ordy;
    logic [NS-1:0] gpre;
    int            n, s;
    #1;
    gpre = grant;
    ordy = out_ready;
    obv  = out_valid && out_ready;
    pov  = out_valid;
    po   = {out_data, out_sop, out_eop, out_empty};
    if (owner >= 0) chk("grant_hold", gpre, NS'(1) << owner);
    for (int i = 0; i < NS; i++) begin
      a[i] = sv[i] && rdy[i];
      last_disc[i] = a[i] && !drv_on[i];
      hb[i] = drv_on[i] ? drv_q[i][0] : '0;
    end
    @(posedge clk);
    #1;
    cyc++;
    n = 0;
    s = -1;
    for (int i = 0; i < NS; i++) if (a[i] && drv_on[i]) begin n++; s = i; end
    chk("one_accept", n > 1, 1'b0);
    if (s >= 0) begin
      void'(drv_q[s].pop_front());
      acc_log.push_back('{cyc, s});
      chk("acc_grant", gpre, NS'(1) << s);
      chk("out_load", {out_valid, out_data, out_sop, out_eop, out_empty}, {1'b1, hb[s]});
      if (hb[s].sop) owner = s;
      if (hb[s].eop) begin
        owner = -1;
        cnt_model[s]++;
        chk("pkt_cnt_inc", cnt_o[s], 16'(cnt_model[s]));
      end
    end else if (ordy) begin
      chk("out_clear", out_valid, 1'b0);
    end else begin
      chk("out_hold", {out_valid, out_data, out_sop, out_eop, out_empty}, {pov, po});
    end
    if (obv) score(po);
    if (proto_err) perr_cnt++;
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while (busy() && k < budget) begin
      drive();
      step();
      k++;
    end
    chk("drain_timeout", busy(), 1'b0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    for (int i = 0; i < NS; i++) begin
      sv[i] = 1'b0; ss[i] = 1'b0; se[i] = 1'b0; drv_on[i] = 1'b0;
      drv_q[i].delete(); exp_q[i].delete();
      cnt_model[i] = 0; sent[i] = 0; rcv_cnt[i] = 0;
    end
    owner = -1;
    cur_src = -1;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    static int exp_src[8] = '{0, 0, 0, 1, 1, 1, 0, 0};
    int nb, bytes;
    for (int i = 0; i < NS; i++) begin
      sv[i] = 1'b0; ss[i] = 1'b0; se[i] = 1'b0; sm[i] = '0; sd[i] = '0; drv_on[i] = 1'b0;
      cnt_model[i] = 0; sent[i] = 0; rcv_cnt[i] = 0;
    end
    out_ready = 1'b1;

    // Reset values, with a stray beat presented to confirm nothing is accepted.
    sv[1] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outs", {out_valid, out_sop, out_eop, out_empty, out_data}, '0);
    chk("rst_ready", src_ready, '0);
    chk("rst_grant", grant, '0);
    chk("rst_perr", proto_err, 1'b0);
    chk("rst_cnt", pkt_cnt, '0);
    sv[1] = 1'b0;
    reset_n = 1'b1;

    // Single source, 3 beats, empty=5.
    add_pkt(0, 3, 3'd5, -1);
    drain(50);
    chk("single_cnt0", cnt_o[0], 16'd1);
    chk("single_cnt1", cnt_o[1], 16'd0);

    // Contention from reset: src0, idle cycle, src1, idle cycle, src0.
    do_reset();
    acc_log.delete();
    add_pkt(0, 3, 3'd0, -1);
    add_pkt(1, 3, 3'd2, -1);
    add_pkt(0, 2, 3'd1, -1);
    drain(80);
    chk("cont_beats", acc_log.size(), 8);
    if (acc_log.size() == 8) begin
      for (int k = 0; k < 8; k++) chk("cont_src", acc_log[k].src, exp_src[k]);
      for (int k = 1; k < 8; k++)
        chk("cont_gap", acc_log[k].cyc - acc_log[k-1].cyc, (k == 3 || k == 6) ? 2 : 1);
    end
    chk("cont_cnt0", cnt_o[0], 16'd2);
    chk("cont_cnt1", cnt_o[1], 16'd1);

    // Backpressure 1,0,0,1 in the middle of a packet.
    ordy_pat = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    add_pkt(0, 6, 3'd3, -1);
    drain(60);

    // Stray non-sop beat from src1 while src0 is locked.
    perr_cnt = 0;
    add_pkt(0, 5, 3'd0, -1);
    repeat (3) begin
      drive();
      step();
    end
    drive();
    sv[1] = 1'b1;
    ss[1] = 1'b0;
    sd[1] = {$urandom, $urandom};
    step();
    chk("err_consumed", last_disc[1], 1'b1);
    drain(60);
    chk("err_pulse", perr_cnt, 1);

    // Repeated sop inside a locked packet is forwarded and flagged.
    perr_cnt = 0;
    add_pkt(0, 4, 3'd0, 2);
    drain(60);
    chk("midsop_pulse", perr_cnt, 1);

    // Reset asserted while beat 2 is presented.
    add_pkt(0, 4, 3'd0, -1);
    repeat (3) begin
      drive();
      step();
    end
    drive();
    #1;
    reset_n = 1'b0;
    #1;
    chk("rstmid_outs", {out_valid, out_sop, out_eop, out_empty, out_data}, '0);
    chk("rstmid_ready", src_ready, '0);
    chk("rstmid_grant", grant, '0);
    chk("rstmid_cnt", pkt_cnt, '0);
    do_reset();
    add_pkt(0, 2, 3'd4, -1);
    drain(40);
    chk("rstmid_cnt0", cnt_o[0], 16'd1);

    // Random soak with upstream gaps and downstream backpressure.
    perr_cnt = 0;
    valid_pct = 70;
    ordy_pct = 75;
    for (int p = 0; p < 30; p++) begin
      for (int s = 0; s < NS; s++) begin
        bytes = int'($urandom_range(1500, 200));
        nb = (bytes + 7) / 8;
        add_pkt(s, nb, 3'(nb * 8 - bytes), -1);
      end
    end
    drain(40000);
    for (int s = 0; s < NS; s++) begin
      chk("soak_pkt_cnt", cnt_o[s], 16'(sent[s]));
      chk("soak_rcv_cnt", rcv_cnt[s], sent[s]);
    end
    chk("soak_no_perr", perr_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
